// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the RV32I hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    MEM_WAIT
  } hz_state_e;

  // Decoders compare the major opcode against this to drive is_load_mem_i.
  localparam logic [6:0] OP_LOAD = 7'b0000011;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forward-source select for one EX operand (MEM over WB over RF)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              rs_used_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              regwen_mem_i,
  input  logic              regwen_wb_i,
  input  logic              is_load_mem_i,
  output fwd_sel_e          sel_o
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet; that case is handled by the load-use stall.
  always_comb begin
    mem_hit = regwen_mem_i && (rd_mem_i != '0) && (rs_i == rd_mem_i) && rs_used_i && !is_load_mem_i;
    wb_hit  = regwen_wb_i && (rd_wb_i != '0) && (rs_i == rd_wb_i) && rs_used_i;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - 5-stage hazard/forwarding controller; HAZARD_PERF_CNT_EN adds saturating perf counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_USE_CYC = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] rs1_ex_i,
  input  logic [REG_AW-1:0] rs2_ex_i,
  input  logic              rs1_used_ex_i,
  input  logic              rs2_used_ex_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              regwen_mem_i,
  input  logic              regwen_wb_i,
  input  logic              is_load_mem_i,
  input  logic              mem_req_i,
  input  logic              dmem_ready_i,
  input  logic              pc_taken_i,
  output logic [1:0]        asel_o,
  output logic [1:0]        bsel_o,
  output logic              pc_sel_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              flush_mem_o,
  output logic              flush_wb_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_events_o
);

  // The first bubble is issued from RUN, so the counter only covers the remaining ones.
  localparam logic [1:0] LU_RELOAD = (LOAD_USE_CYC > 1) ? 2'(LOAD_USE_CYC - 2) : 2'd0;

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  fwd_sel_e   asel, bsel;
  logic       load_use, mem_wait;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i(rs1_ex_i), .rs_used_i(rs1_used_ex_i), .rd_mem_i(rd_mem_i), .rd_wb_i(rd_wb_i),
    .regwen_mem_i(regwen_mem_i), .regwen_wb_i(regwen_wb_i), .is_load_mem_i(is_load_mem_i),
    .sel_o(asel)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i(rs2_ex_i), .rs_used_i(rs2_used_ex_i), .rd_mem_i(rd_mem_i), .rd_wb_i(rd_wb_i),
    .regwen_mem_i(regwen_mem_i), .regwen_wb_i(regwen_wb_i), .is_load_mem_i(is_load_mem_i),
    .sel_o(bsel)
  );

  assign load_use = is_load_mem_i && regwen_mem_i && (rd_mem_i != '0) &&
                    ((rs1_used_ex_i && (rs1_ex_i == rd_mem_i)) ||
                     (rs2_used_ex_i && (rs2_ex_i == rd_mem_i)));
  assign mem_wait = mem_req_i && !dmem_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_mem_o = 1'b0;
    flush_wb_o  = 1'b0;
    case (state_q)
      LU_BUBBLE: begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        flush_mem_o = 1'b1;
        if (mem_wait) begin
          state_d = MEM_WAIT;
          cnt_d   = 2'd0;
        end else if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      // RUN and MEM_WAIT share logic: MEM_WAIT releases as soon as mem_wait drops.
      default: begin
        if (mem_wait) begin
          stall_if_o  = 1'b1;
          stall_id_o  = 1'b1;
          stall_ex_o  = 1'b1;
          stall_mem_o = 1'b1;
          flush_wb_o  = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            flush_mem_o = 1'b1;
            if (LOAD_USE_CYC > 1) begin
              state_d = LU_BUBBLE;
              cnt_d   = LU_RELOAD;
            end
          end
        end
      end
    endcase
    if (!rst_ni) begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_mem_o = 1'b0;
      flush_wb_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A taken branch sitting in a held EX waits until EX is allowed to advance.
  assign pc_sel_o   = rst_ni && pc_taken_i && !stall_ex_o;
  assign flush_id_o = pc_sel_o;
  assign flush_ex_o = pc_sel_o;
  assign asel_o     = rst_ni ? asel : FWD_RF;
  assign bsel_o     = rst_ni ? bsel : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_sel_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_events_o = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit with LOAD_USE_CYC=1 and LOAD_USE_CYC=3
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1, rs2, rdm, rdw;
  logic       u1, u2, wm, ww, ld, rq, rdy, tk;

  logic [1:0]  asel1, bsel1, asel3, bsel3;
  logic        pcs1, sif1, sid1, sex1, smem1, fid1, fex1, fmem1, fwb1;
  logic        pcs3, sif3, sid3, sex3, smem3, fid3, fex3, fmem3, fwb3;
  logic [31:0] sc1, fe1;
  logic [1:0]  sc3, fe3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [12:0] e1;
    logic [12:0] e3;
  } exp_t;
  exp_t sb_q[$];

  // {asel, bsel, pc_sel, stall if/id/ex/mem, flush id/ex/mem/wb}
  localparam logic [12:0] Z  = 13'b00_00_0_0000_0000;
  localparam logic [12:0] LU = 13'b00_00_0_1110_0010;
  localparam logic [12:0] MW = 13'b00_00_0_1111_0001;
  localparam logic [12:0] BR = 13'b00_00_1_0000_1100;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYC(1), .CNT_W(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rs1_ex_i(rs1), .rs2_ex_i(rs2),
    .rs1_used_ex_i(u1), .rs2_used_ex_i(u2), .rd_mem_i(rdm), .rd_wb_i(rdw),
    .regwen_mem_i(wm), .regwen_wb_i(ww), .is_load_mem_i(ld), .mem_req_i(rq),
    .dmem_ready_i(rdy), .pc_taken_i(tk), .asel_o(asel1), .bsel_o(bsel1),
    .pc_sel_o(pcs1), .stall_if_o(sif1), .stall_id_o(sid1), .stall_ex_o(sex1),
    .stall_mem_o(smem1), .flush_id_o(fid1), .flush_ex_o(fex1), .flush_mem_o(fmem1),
    .flush_wb_o(fwb1), .stall_cycles_o(sc1), .flush_events_o(fe1)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYC(3), .CNT_W(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .rs1_ex_i(rs1), .rs2_ex_i(rs2),
    .rs1_used_ex_i(u1), .rs2_used_ex_i(u2), .rd_mem_i(rdm), .rd_wb_i(rdw),
    .regwen_mem_i(wm), .regwen_wb_i(ww), .is_load_mem_i(ld), .mem_req_i(rq),
    .dmem_ready_i(rdy), .pc_taken_i(tk), .asel_o(asel3), .bsel_o(bsel3),
    .pc_sel_o(pcs3), .stall_if_o(sif3), .stall_id_o(sid3), .stall_ex_o(sex3),
    .stall_mem_o(smem3), .flush_id_o(fid3), .flush_ex_o(fex3), .flush_mem_o(fmem3),
    .flush_wb_o(fwb3), .stall_cycles_o(sc3), .flush_events_o(fe3)
  );

  wire logic [12:0] obs1 = {asel1, bsel1, pcs1, sif1, sid1, sex1, smem1, fid1, fex1, fmem1, fwb1};
  wire logic [12:0] obs3 = {asel3, bsel3, pcs3, sif3, sid3, sex3, smem3, fid3, fex3, fmem3, fwb3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] fw(input logic [1:0] a, input logic [1:0] b, input logic [12:0] base);
    return {a, b, base[8:0]};
  endfunction

  // Inputs change just after the active edge; outputs are sampled on the falling edge.
  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic a1, input logic a2,
                        input logic [4:0] m, input logic [4:0] w, input logic em, input logic ew,
                        input logic l, input logic q, input logic r, input logic t);
    @(posedge clk);
    #1;
    rs1 = r1; rs2 = r2; u1 = a1; u2 = a2; rdm = m; rdw = w;
    wm = em; ww = ew; ld = l; rq = q; rdy = r; tk = t;
  endtask

  task automatic idle_in(input logic t);
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
  endtask

  task automatic push_chk(input string tag, input logic [12:0] e1, input logic [12:0] e3);
    exp_t e;
    e.tag = tag; e.e1 = e1; e.e3 = e3;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk($sformatf("%s/cyc1", e.tag), 32'(obs1), 32'(e.e1));
    chk($sformatf("%s/cyc3", e.tag), 32'(obs3), 32'(e.e3));
  endtask

  initial begin
    rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rdm = '0; rdw = '0;
    wm = 0; ww = 0; ld = 0; rq = 0; rdy = 1; tk = 0;

    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push_chk("reset", Z, Z);
    chk("reset_sc1", sc1, 32'd0);
    chk("reset_fe3", 32'(fe3), 32'd0);
    rst_n = 1'b1;

    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_chk("fwd_mem", fw(2'b01, 2'b00, Z), fw(2'b01, 2'b00, Z));
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push_chk("fwd_prio", fw(2'b01, 2'b00, Z), fw(2'b01, 2'b00, Z));
    set_in(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push_chk("fwd_x0_wb", fw(2'b00, 2'b10, Z), fw(2'b00, 2'b10, Z));

    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_chk("lu_c1", LU, LU);
    for (int i = 0; i < 3; i++) begin
      set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      push_chk($sformatf("lu_after%0d", i), fw(2'b00, 2'b10, Z), fw(2'b00, 2'b10, (i < 2) ? LU : Z));
    end
    set_in(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_chk("lu_unused", Z, Z);

    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_chk("rst_mid_c1", LU, LU);
    idle_in(1'b0);
    rst_n = 1'b0;
    push_chk("rst_mid_c2", Z, Z);
    chk("rst_mid_sc3", 32'(sc3), 32'd0);
    rst_n = 1'b1;
    idle_in(1'b0);
    push_chk("rst_release", Z, Z);

    for (int i = 0; i < 4; i++) begin
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_chk($sformatf("sw_wait%0d", i), MW, MW);
    end
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    push_chk("sw_ready", BR, BR);
    idle_in(1'b0);
    push_chk("sw_done", Z, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_sc1", sc1, 32'd4);
    chk("perf_fe1", fe1, 32'd1);
    chk("perf_sc3_sat", 32'(sc3), 32'd3);
    chk("perf_fe3", 32'(fe3), 32'd1);
`else
    chk("perf_sc1", sc1, 32'd0);
    chk("perf_fe1", fe1, 32'd0);
    chk("perf_sc3", 32'(sc3), 32'd0);
    chk("perf_fe3", 32'(fe3), 32'd0);
`endif

    idle_in(1'b1);
    push_chk("br_plain", BR, BR);

    set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push_chk("br_lu_c1", LU, LU);
    for (int i = 0; i < 3; i++) begin
      idle_in(1'b1);
      push_chk($sformatf("br_lu_after%0d", i), BR, (i < 2) ? LU : BR);
    end

    set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_chk("lu_mw_c1", LU, LU);
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_chk("lu_mw_c2", MW, LU);
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_chk("lu_mw_c3", MW, MW);
    idle_in(1'b0);
    push_chk("lu_mw_c4", Z, Z);

    set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_chk("mw_lu_c1", MW, MW);
    set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_chk("mw_lu_c2", LU, LU);
    for (int i = 0; i < 3; i++) begin
      idle_in(1'b0);
      push_chk($sformatf("mw_lu_after%0d", i), Z, (i < 2) ? LU : Z);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
